// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC, single-outstanding imem handshake and IF/ID register
//
// Ports:
//   clk, reset (async, active-low)
//   stall_if                       hazard stall: hold PC and IF/ID
//   branch_taken / branch_target   EX redirect (highest priority)
//   jump_en / jump_target          ID redirect
//   imem_req / imem_addr           fetch request, address stable until imem_rvalid
//   imem_rvalid / imem_rdata       fetch response (zero-wait or delayed)
//   inst_id / pc_id / pc_plus4_id / valid_id   IF/ID register to decode
// Optional: define IF_PERF_CNT_EN to add fetch_cnt, stall_cnt and flush_cnt outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RST, FETCH, HOLD, KILL} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, buf_q, buf_d;
  logic [31:0] inst_q, inst_d, pcid_q, pcid_d, pc4_q, pc4_d;
  logic        valid_q, valid_d, fetch_v;
  logic        redirect;
  logic [31:0] target, pc_inc;
  assign redirect = branch_taken | jump_en;
  assign target = {(branch_taken ? branch_target[31:2] : jump_target[31:2]), 2'b00};
  assign pc_inc = pc_q + 32'd4;
  assign imem_req = (state_q == FETCH) || (state_q == KILL);
  // In KILL the PC already points at the redirect target; the request in
  // flight must keep its original address until its response drains.
  assign imem_addr = (state_q == KILL) ? addr_q : pc_q;
  assign inst_id = inst_q;
  assign pc_id = pcid_q;
  assign pc_plus4_id = pc4_q;
  assign valid_id = valid_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    buf_d = buf_q;
    inst_d = inst_q;
    pcid_d = pcid_q;
    pc4_d = pc4_q;
    valid_d = valid_q;
    fetch_v = 1'b0;
    case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        addr_d = pc_q;
        if (redirect) begin
          inst_d = NOP_INST;
          valid_d = 1'b0;
          pc_d = target;
          state_d = imem_rvalid ? FETCH : KILL;
        end else if (imem_rvalid && !stall_if) begin
          inst_d = imem_rdata;
          pcid_d = pc_q;
          pc4_d = pc_inc;
          valid_d = 1'b1;
          pc_d = pc_inc;
          fetch_v = 1'b1;
        end else if (imem_rvalid) begin
          buf_d = imem_rdata;
          state_d = HOLD;
        end else if (!stall_if) begin
          inst_d = NOP_INST;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          inst_d = NOP_INST;
          valid_d = 1'b0;
          buf_d = NOP_INST;
          pc_d = target;
          state_d = FETCH;
        end else if (!stall_if) begin
          inst_d = buf_q;
          pcid_d = pc_q;
          pc4_d = pc_inc;
          valid_d = 1'b1;
          pc_d = pc_inc;
          fetch_v = 1'b1;
          state_d = FETCH;
        end
      end
      KILL: begin
        inst_d = NOP_INST;
        valid_d = 1'b0;
        pc_d = redirect ? target : pc_q;
        state_d = imem_rvalid ? FETCH : KILL;
      end
      default: state_d = RST;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      buf_q <= NOP_INST;
      inst_q <= NOP_INST;
      pcid_q <= 32'd0;
      pc4_q <= 32'd4;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      buf_q <= buf_d;
      inst_q <= inst_d;
      pcid_q <= pcid_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'd0, fetch_v};
      stall_cnt <= stall_cnt + {31'd0, stall_if};
      flush_cnt <= flush_cnt + {31'd0, redirect};
    end
  end
`else
  logic unused_fetch_v;
  assign unused_fetch_v = fetch_v;
`endif
endmodule
